// File: rtl/cache_pkg.sv
// cache_pkg: shared types and geometry helpers for the direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    // Controller states: IDLE serves hits and decodes requests, FILL waits on a
    // memory read for a load miss, WRITE waits on a write-through store.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Index bits select one of SETS one-word lines (SETS must be a power of two, >= 2).
    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag is everything above the index and the two byte-offset bits.
    function automatic int tag_bits(input int addr_width, input int sets);
        return addr_width - $clog2(sets) - 2;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: CPU-side request/response and memory-side request/ack bundle.
// Latency: n/a (wiring only).
// Backpressure: CPU holds its request while stall_o is high; memory completes each request with one mem_ack_i pulse.
//
// Ports (slave = cache view):
//   CPU   : addr_i, wdata_i, re_i, we_i in; rdata_o, stall_o out
//   Memory: mem_rdata_i, mem_ack_i in; mem_addr_o, mem_wdata_o, mem_re_o, mem_we_o out
//   Stats : hit_count_o, miss_count_o out
interface data_cache_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  re_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  stall_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_re_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;
    logic [15:0]           hit_count_o;
    logic [15:0]           miss_count_o;

    modport slave (
        input  addr_i, wdata_i, re_i, we_i, mem_rdata_i, mem_ack_i,
        output rdata_o, stall_o, mem_addr_o, mem_wdata_o, mem_re_o, mem_we_o,
               hit_count_o, miss_count_o
    );

    modport master (
        output addr_i, wdata_i, re_i, we_i, mem_rdata_i, mem_ack_i,
        input  rdata_o, stall_o, mem_addr_o, mem_wdata_o, mem_re_o, mem_we_o,
               hit_count_o, miss_count_o
    );

endinterface

// File: rtl/dcache_array.sv
// dcache_array: data, tag and valid storage for a direct-mapped one-word-per-line cache.
// Latency: reads are combinational; writes land on the rising clock edge.
// Backpressure: none; a single write port, the controller decides when to write.
//
// Ports: clk_i; clr_i clears every valid bit (data/tags kept); we_i writes data+tag
// and sets valid at idx_i; rdata_o/rtag_o/rvalid_o read line idx_i asynchronously.
module dcache_array #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 3,
    parameter int TAG_W      = 27
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [TAG_W-1:0]      rtag_o,
    output logic                  rvalid_o
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]      tag_q  [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    // Payload storage has no reset: only the valid bits decide whether a line is usable.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_q[idx_i] <= wdata_i;
            tag_q[idx_i]  <= tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    assign rdata_o  = data_q[idx_i];
    assign rtag_o   = tag_q[idx_i];
    assign rvalid_o = valid_q[idx_i];

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache with hit/miss counters.
// Latency: load hit 0 cycles (combinational rdata_o); load miss = ack wait + 2 cycles; store = ack wait + 2 cycles.
// Backpressure: stall_o tells the CPU to hold its request; memory requests stay up until mem_ack_i.
//
// Ports: clk_i, rst_i (synchronous, active-high); bus (data_cache_if.slave) carries
// the CPU request/response, the memory request/ack and the two saturating counters.
module data_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    data_cache_if.slave bus
);
    localparam int IDX_W = index_bits(SETS);
    localparam int TAG_W = tag_bits(ADDR_WIDTH, SETS);

    state_e state_q, state_d;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic [TAG_W-1:0]      line_tag;
    logic                  line_valid;
    logic                  hit;

    logic                  rst_q;      // high the cycle after reset
    logic                  done_q;     // high the cycle after a FILL/WRITE completed
    logic                  blocked;
    logic                  is_store, is_load, idle_live;
    logic                  start_store, start_fill, load_hit;

    logic                  stall, mem_re, mem_we;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  arr_we;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic                  count_hit, count_miss;
    logic [CNT_W-1:0]      hit_cnt_q, miss_cnt_q;

    logic                  unused_addr_bits;

    // Byte offset bits never matter for a word cache.
    assign unused_addr_bits = ^bus.addr_i[1:0];

    assign idx = bus.addr_i[IDX_W+1:2];
    assign tag = bus.addr_i[ADDR_WIDTH-1:IDX_W+2];
    assign hit = line_valid & (line_tag == tag);

    dcache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk_i    (clk_i),
        .clr_i    (rst_i),
        .we_i     (arr_we),
        .idx_i    (idx),
        .tag_i    (tag),
        .wdata_i  (arr_wdata),
        .rdata_o  (line_data),
        .rtag_o   (line_tag),
        .rvalid_o (line_valid)
    );

    // Request decode. While in reset and for one cycle after it, the cache ignores
    // the CPU entirely so that no stall or memory request can leak out.
    assign blocked   = rst_i | rst_q;
    assign is_store  = bus.we_i;                 // re_i & we_i counts as a store
    assign is_load   = bus.re_i & ~bus.we_i;
    assign idle_live = (state_q == IDLE) & ~blocked;

    // The CPU still presents its request during the cycle right after completion
    // (it only sees stall_o drop then). done_q marks that cycle: a held store must
    // not be issued a second time, and a held load is the tail of an already
    // counted miss, so it returns data without bumping the hit counter.
    assign start_store = idle_live & is_store & ~done_q;
    assign start_fill  = idle_live & is_load & ~hit;
    assign load_hit    = idle_live & is_load & hit;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_store) begin
                    state_d = WRITE;
                end else if (start_fill) begin
                    state_d = FILL;
                end
            end
            FILL:    if (bus.mem_ack_i) state_d = IDLE;
            WRITE:   if (bus.mem_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Requests are masked by rst_i so a reset mid-transfer drops
    // them immediately and never updates the line.
    always_comb begin
        stall      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        rdata      = '0;
        arr_we     = 1'b0;
        arr_wdata  = bus.mem_rdata_i;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall      = start_store | start_fill;
                if (load_hit) begin
                    rdata = line_data;
                end
                count_hit  = (start_store & hit) | (load_hit & ~done_q);
                count_miss = (start_store & ~hit) | start_fill;
            end
            FILL: begin
                mem_re = ~rst_i;
                stall  = ~rst_i;
                arr_we = bus.mem_ack_i & ~rst_i;
            end
            WRITE: begin
                mem_we    = ~rst_i;
                stall     = ~rst_i;
                // Write-through: only refresh the line if it already holds this address.
                arr_we    = bus.mem_ack_i & hit & ~rst_i;
                arr_wdata = bus.wdata_i;
            end
            default: ;
        endcase
    end

    // Completion marker, post-reset marker and statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_q      <= 1'b1;
            done_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            rst_q  <= 1'b0;
            done_q <= (state_q != IDLE) & bus.mem_ack_i;
            if (count_hit) begin
                hit_cnt_q <= sat_inc(hit_cnt_q);
            end
            if (count_miss) begin
                miss_cnt_q <= sat_inc(miss_cnt_q);
            end
        end
    end

    assign bus.rdata_o      = rdata;
    assign bus.stall_o      = stall;
    assign bus.mem_re_o     = mem_re;
    assign bus.mem_we_o     = mem_we;
    assign bus.mem_addr_o   = {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata_o  = bus.wdata_i;
    assign bus.hit_count_o  = hit_cnt_q;
    assign bus.miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache.
// Latency: n/a.
// Backpressure: the bench holds each CPU request until stall_o drops and acks memory after a chosen wait.
module tb_data_cache;

    logic clk_i = 1'b0;
    logic rst_i;

    data_cache_if bus ();

    data_cache dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int          stalls;
        int          re_cyc;
        int          we_cyc;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic [31:0] rdata;
        int          bad;
    } acc_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one CPU access and hold it until stall_o drops; ack the memory
    // request after ack_wait request cycles. Starts and ends 1 unit after a rising edge.
    task automatic run_access(input logic [31:0] a, input logic [31:0] wd,
                              input logic rd, input logic wr,
                              input int ack_wait, input logic [31:0] rsp,
                              output acc_t r);
        int waited   = 0;
        bit finished = 1'b0;
        r = '{0, 0, 0, 32'h0, 32'h0, 32'h0, 0};
        bus.addr_i  = a;
        bus.wdata_i = wd;
        bus.re_i    = rd;
        bus.we_i    = wr;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (bus.mem_re_o && bus.mem_we_o) r.bad++;
            if (bus.stall_o && bus.rdata_o != 32'h0) r.bad++;
            if (bus.stall_o) r.stalls++;
            if (bus.mem_re_o) r.re_cyc++;
            if (bus.mem_we_o) r.we_cyc++;
            if (bus.mem_re_o || bus.mem_we_o) begin
                r.req_addr  = bus.mem_addr_o;
                r.req_wdata = bus.mem_wdata_o;
                if (waited == ack_wait) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = rsp;
                end else begin
                    waited++;
                end
            end
            if (!bus.stall_o) begin
                r.rdata  = bus.rdata_o;
                finished = 1'b1;
            end
            @(posedge clk_i); #1;
            bus.mem_ack_i = 1'b0;
            if (finished) break;
        end
        check("access_completes", finished, 1);
        bus.re_i = 1'b0;
        bus.we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        acc_t r;
        rst_i           = 1'b1;
        bus.addr_i      = 32'h100;
        bus.wdata_i     = 32'h0;
        bus.re_i        = 1'b1;
        bus.we_i        = 1'b0;
        bus.mem_rdata_i = 32'h0;
        bus.mem_ack_i   = 1'b0;

        // Reset: outputs quiet while in reset and the cycle after, counters cleared.
        @(negedge clk_i);
        check("rst_stall", bus.stall_o, 0);
        check("rst_mem_re", bus.mem_re_o, 0);
        check("rst_mem_we", bus.mem_we_o, 0);
        @(posedge clk_i); #1;
        check("rst_hit_cnt", bus.hit_count_o, 0);
        check("rst_miss_cnt", bus.miss_count_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_stall", bus.stall_o, 0);
        check("post_rst_mem_re", bus.mem_re_o, 0);
        check("post_rst_rdata", bus.rdata_o, 0);
        @(posedge clk_i); #1;
        bus.re_i = 1'b0;

        // Cold load miss with ack after 3 cycles.
        run_access(32'h100, 32'h0, 1'b1, 1'b0, 3, 32'hDEADBEEF, r);
        check("miss1_stalls", r.stalls, 5);
        check("miss1_mem_re_cycles", r.re_cyc, 4);
        check("miss1_mem_addr", r.req_addr, 32'h100);
        check("miss1_rdata", r.rdata, 32'hDEADBEEF);
        check("miss1_bad", r.bad, 0);
        check("miss1_miss_cnt", bus.miss_count_o, 1);
        check("miss1_hit_cnt", bus.hit_count_o, 0);

        // Repeat load: zero-stall hit.
        run_access(32'h100, 32'h0, 1'b1, 1'b0, 0, 32'h0, r);
        check("hit1_stalls", r.stalls, 0);
        check("hit1_mem_re", r.re_cyc, 0);
        check("hit1_rdata", r.rdata, 32'hDEADBEEF);
        check("hit1_hit_cnt", bus.hit_count_o, 1);

        // No request: nothing happens.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("idle_quiet", {bus.stall_o, bus.mem_re_o, bus.mem_we_o}, 3'b000);
            @(posedge clk_i); #1;
        end
        check("idle_hit_cnt", bus.hit_count_o, 1);
        check("idle_miss_cnt", bus.miss_count_o, 1);

        // Store hit: write-through and line update.
        run_access(32'h100, 32'h12345678, 1'b0, 1'b1, 0, 32'h0, r);
        check("st_hit_stalls", r.stalls, 2);
        check("st_hit_we", r.we_cyc, 1);
        check("st_hit_re", r.re_cyc, 0);
        check("st_hit_addr", r.req_addr, 32'h100);
        check("st_hit_wdata", r.req_wdata, 32'h12345678);
        check("st_hit_hit_cnt", bus.hit_count_o, 2);
        run_access(32'h100, 32'h0, 1'b1, 1'b0, 0, 32'h0, r);
        check("ld_after_st_stalls", r.stalls, 0);
        check("ld_after_st_rdata", r.rdata, 32'h12345678);
        check("ld_after_st_hit_cnt", bus.hit_count_o, 3);

        // Store miss to same index: no allocation, later load misses.
        run_access(32'h200, 32'hCAFE0200, 1'b0, 1'b1, 0, 32'h0, r);
        check("st_miss_we", r.we_cyc, 1);
        check("st_miss_addr", r.req_addr, 32'h200);
        check("st_miss_miss_cnt", bus.miss_count_o, 2);
        run_access(32'h200, 32'h0, 1'b1, 1'b0, 1, 32'hA5A50001, r);
        check("ld200_re_cycles", r.re_cyc, 2);
        check("ld200_stalls", r.stalls, 3);
        check("ld200_rdata", r.rdata, 32'hA5A50001);
        check("ld200_miss_cnt", bus.miss_count_o, 3);

        // Conflict replacement within index 0.
        run_access(32'h100, 32'h0, 1'b1, 1'b0, 0, 32'hDEADBEEF, r);
        check("refill100_re", r.re_cyc, 1);
        run_access(32'h120, 32'h0, 1'b1, 1'b0, 0, 32'hCAFEF00D, r);
        check("ld120_re", r.re_cyc, 1);
        check("ld120_stalls", r.stalls, 2);
        check("ld120_rdata", r.rdata, 32'hCAFEF00D);
        run_access(32'h100, 32'h0, 1'b1, 1'b0, 0, 32'h0BADF00D, r);
        check("ld100_evicted_re", r.re_cyc, 1);
        check("ld100_evicted_rdata", r.rdata, 32'h0BADF00D);
        check("conflict_miss_cnt", bus.miss_count_o, 6);

        // re_i and we_i together behave as a store.
        run_access(32'h100, 32'h55AA55AA, 1'b1, 1'b1, 0, 32'hFFFFFFFF, r);
        check("rw_we", r.we_cyc, 1);
        check("rw_re", r.re_cyc, 0);
        check("rw_bad", r.bad, 0);
        check("rw_hit_cnt", bus.hit_count_o, 4);

        // Stray ack in IDLE is ignored.
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hFFFFFFFF;
        @(negedge clk_i);
        check("stray_ack_quiet", {bus.stall_o, bus.mem_re_o, bus.mem_we_o}, 3'b000);
        @(posedge clk_i); #1;
        bus.mem_ack_i = 1'b0;
        run_access(32'h100, 32'h0, 1'b1, 1'b0, 0, 32'h0, r);
        check("stray_ack_rdata", r.rdata, 32'h55AA55AA);
        check("stray_ack_stalls", r.stalls, 0);
        check("stray_ack_hit_cnt", bus.hit_count_o, 5);

        // Reset during FILL aborts; the late ack is ignored.
        bus.addr_i = 32'h140;
        bus.re_i   = 1'b1;
        @(negedge clk_i);
        check("abort_miss_stall", bus.stall_o, 1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("abort_fill_mem_re", bus.mem_re_o, 1);
        check("abort_fill_addr", bus.mem_addr_o, 32'h140);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_in_rst_mem_re", bus.mem_re_o, 0);
        check("abort_in_rst_stall", bus.stall_o, 0);
        @(posedge clk_i); #1;
        rst_i           = 1'b0;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h77777777;
        @(negedge clk_i);
        check("abort_next_mem_re", bus.mem_re_o, 0);
        check("abort_next_stall", bus.stall_o, 0);
        check("abort_hit_cnt", bus.hit_count_o, 0);
        check("abort_miss_cnt", bus.miss_count_o, 0);
        @(posedge clk_i); #1;
        bus.mem_ack_i = 1'b0;
        bus.re_i      = 1'b0;
        run_access(32'h140, 32'h0, 1'b1, 1'b0, 0, 32'h99999999, r);
        check("ld140_re", r.re_cyc, 1);
        check("ld140_stalls", r.stalls, 2);
        check("ld140_rdata", r.rdata, 32'h99999999);
        check("ld140_miss_cnt", bus.miss_count_o, 1);

        // Hit counter saturation.
        force dut.hit_cnt_q = 16'hFFFE;
        @(posedge clk_i); #1;
        release dut.hit_cnt_q;
        check("sat_preload", bus.hit_count_o, 16'hFFFE);
        run_access(32'h140, 32'h0, 1'b1, 1'b0, 0, 32'h0, r);
        check("sat_hit1", bus.hit_count_o, 16'hFFFF);
        for (int i = 0; i < 2; i++) begin
            run_access(32'h140, 32'h0, 1'b1, 1'b0, 0, 32'h0, r);
            check("sat_hit_stalls", r.stalls, 0);
        end
        check("sat_final", bus.hit_count_o, 16'hFFFF);
        check("sat_rdata", r.rdata, 32'h99999999);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of CPU and memory data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter SETS, default 8, number of direct-mapped one-word lines (power of two).
REQ-004 SHALL have ports:
- clk_i  in  1  the block's single clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- addr_i  in  ADDR_WIDTH  CPU byte address; bits [1:0] ignored.
- wdata_i  in  DATA_WIDTH  CPU store data.
- re_i  in  1  CPU load request.
- we_i  in  1  CPU store request.
- rdata_o  out  DATA_WIDTH  load data.
- stall_o  out  1  CPU must hold addr_i/wdata_i/re_i/we_i stable while high.
- mem_addr_o  out  ADDR_WIDTH  word-aligned address to main memory.
- mem_wdata_o  out  DATA_WIDTH  write-through data.
- mem_re_o  out  1  memory read request.
- mem_we_o  out  1  memory write request.
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completion strobe, one cycle per request.
- hit_count_o  out  16  saturating hit counter.
- miss_count_o  out  16  saturating miss counter.

Function
REQ-005 Index SHALL be addr_i[log2(SETS)+1:2]; tag SHALL be addr_i[ADDR_WIDTH-1:log2(SETS)+2]; hit = valid[index] & tag match.
REQ-006 FSM states SHALL be IDLE, FILL, WRITE.
REQ-007 IDLE, re_i & ~we_i & hit: rdata_o = line data combinationally, stall_o=0, hit_count increments at clock edge.
REQ-008 IDLE, re_i & ~we_i & miss: stall_o=1 same cycle; next state FILL; miss_count increments.
REQ-009 FILL: mem_re_o=1, mem_addr_o = {addr_i[ADDR_WIDTH-1:2],2'b00}, stall_o=1; on mem_ack_i, line[index] <= mem_rdata_i, tag written, valid set, next state IDLE; re-presented load then hits (miss latency = ack wait + 2 cycles).
REQ-010 IDLE, we_i: stall_o=1 same cycle; next state WRITE; counted as hit or miss by REQ-005.
REQ-011 WRITE: mem_we_o=1, mem_addr_o word-aligned addr_i, mem_wdata_o = wdata_i, stall_o=1; on mem_ack_i, if hit, line data <= wdata_i (write-through); if miss, no allocation; next state IDLE.
REQ-012 re_i and we_i both high SHALL be treated as store only.
REQ-013 re_i=we_i=0 in IDLE: stall_o=0, no memory request, counters unchanged.
REQ-014 mem_re_o and mem_we_o SHALL never be high together; both SHALL be 0 in IDLE.
REQ-015 Counters SHALL saturate at 16'hFFFF, not wrap.
REQ-016 mem_ack_i in IDLE SHALL be ignored.
REQ-017 rdata_o SHALL be 0 when not (IDLE & read hit).

Reset
REQ-018 rst_i high at a clock edge SHALL clear all valid bits, counters to 0, state to IDLE; line data/tags unchanged.
REQ-019 While rst_i high and the cycle after, stall_o, mem_re_o, mem_we_o SHALL be 0.
REQ-020 rst_i during FILL or WRITE SHALL abort: no line update, request deasserted next cycle, late ack ignored.

Structure
REQ-021 Package cache_pkg SHALL hold the state enum and index/tag width derivation functions.
REQ-022 Storage (data, tag, valid arrays, one write port, async read) SHALL be sub-module dcache_array.

Verification
REQ-023 Reset, load 0x100 with ack after 3 cycles returning 0xDEADBEEF -> stall_o high 5 cycles, mem_re_o high 4, then rdata_o=0xDEADBEEF, stall_o=0, miss_count=1.
REQ-024 Repeat load 0x100 -> zero-stall hit, rdata_o=0xDEADBEEF, hit_count=1, no mem_re_o.
REQ-025 Store 0x12345678 to 0x100 (hit) -> mem_we_o with mem_addr_o=0x100, after ack load 0x100 hits returning 0x12345678; store to 0x200 (miss, same index) -> no allocation, load 0x200 misses.
REQ-026 Load 0x120 (tag differs, index 0) after 0x100 cached -> miss, line replaced, load 0x100 then misses.
REQ-027 rst_i during FILL for 0x140 -> mem_re_o 0 next cycle, later ack ignored, load 0x140 misses again.
REQ-028 Force hit_count to 0xFFFE, issue 3 hits -> hit_count_o=0xFFFF.
